// File: rtl/l1_pkg.sv
// Shared definitions for the L1 refill controller: address field widths,
// the sequencer state encoding and address slicing helpers.
package l1_pkg;

  localparam int L1_TAG_W      = 23;
  localparam int L1_SET_W      = 4;
  localparam int L1_WORD_W     = 3;
  localparam int L1_LINE_WORDS = 8;

  // Refill sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } l1_state_e;

  // Byte address layout: tag[31:9] | set[8:5] | word[4:2] | byte[1:0]
  function automatic logic [L1_TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:9];
  endfunction

  function automatic logic [L1_SET_W-1:0] addr_set(input logic [31:0] addr);
    return addr[8:5];
  endfunction

  // Rebuild a word-aligned byte address from its line fields
  function automatic logic [31:0] word_addr(input logic [L1_TAG_W-1:0]  tag,
                                            input logic [L1_SET_W-1:0]  set,
                                            input logic [L1_WORD_W-1:0] word);
    return {tag, set, word, 2'b00};
  endfunction

  // 32-bit counter increment that sticks at all-ones
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/l1_victim_sel.sv
// Victim selection for line allocation: the lowest-index invalid line wins;
// when every line is valid the round-robin pointer is used and advanced.
module l1_victim_sel
  import l1_pkg::*;
#(
  parameter int NUM_LINES = 8,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] valid_i,
  input  logic                 alloc_i,
  output logic [IDX_W-1:0]     victim_o
);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;
  logic             found_s;

  // Priority-encode the first invalid line, falling back to the pointer
  always_comb begin
    victim_o = rr_q;
    found_s  = 1'b0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        victim_o = IDX_W'(i);
        found_s  = 1'b1;
      end
    end
  end

  // Pointer only moves when it actually supplied the victim
  always_comb begin
    if (alloc_i && !found_s) begin
      rr_d = rr_q + IDX_W'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/l1_refill_ctrl.sv
// Miss/refill sequencer for a fully-associative array of 8-word L1 lines.
// Owns per-line valid/tag/set state, detects read misses, allocates a victim
// and refills it word by word from the memory port.
// Optional build macro L1_REFILL_STATS_EN adds saturating hit/miss/fill-cycle
// counters as extra outputs.
module l1_refill_ctrl
  import l1_pkg::*;
#(
  parameter int NUM_LINES  = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_rreq,
  input  logic                          cpu_wreq,
  input  logic [31:0]                   cpu_addr,
  output logic                          cpu_stall,
  input  logic [NUM_LINES-1:0]          hit_vec,
  input  logic                          inv_all,
  output logic [NUM_LINES-1:0]          line_valid,
  output logic [NUM_LINES*L1_TAG_W-1:0] line_tag,
  output logic [NUM_LINES*L1_SET_W-1:0] line_set,
  output logic                          fill_active,
  output logic                          fill_wreq,
  output logic [31:0]                   fill_addr,
  output logic [31:0]                   fill_wdata,
  output logic                          mem_req,
  output logic [31:0]                   mem_addr,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata
`ifdef L1_REFILL_STATS_EN
  ,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt,
  output logic [31:0]                   fill_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);

  l1_state_e                              state_q, state_d;
  logic [L1_TAG_W-1:0]                    miss_tag_q, miss_tag_d;
  logic [L1_SET_W-1:0]                    miss_set_q, miss_set_d;
  logic [IDX_W-1:0]                       victim_q, victim_d;
  logic [L1_WORD_W-1:0]                   wc_q, wc_d;
  logic [NUM_LINES-1:0]                   valid_q, valid_d;
  logic [NUM_LINES-1:0][L1_TAG_W-1:0]     tag_q, tag_d;
  logic [NUM_LINES-1:0][L1_SET_W-1:0]     set_q, set_d;

  logic                                   miss_s;
  logic                                   alloc_start_s;
  logic [IDX_W-1:0]                       sel_victim_s;
  logic                                   unused_s;

  // Writes are write-no-allocate and the word/byte offset never matters here
  assign unused_s      = ^{cpu_wreq, cpu_addr[4:0]};

  assign miss_s        = cpu_rreq & ~(|hit_vec);
  assign alloc_start_s = (state_q == IDLE) & miss_s & ~inv_all;

  l1_victim_sel #(
    .NUM_LINES (NUM_LINES)
  ) u_victim_sel (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_q),
    .alloc_i  (alloc_start_s),
    .victim_o (sel_victim_s)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush abandons any refill in progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (alloc_start_s) begin
          state_d = ALLOC;
        end else begin
          state_d = IDLE;
        end
      end
      ALLOC: begin
        if (inv_all) begin
          state_d = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (inv_all) begin
          state_d = IDLE;
        end else if (mem_ack && (wc_q == 3'd7)) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state; the word arriving with a flush is dropped
  always_comb begin
    cpu_stall   = 1'b0;
    fill_active = 1'b0;
    mem_req     = 1'b0;
    fill_wreq   = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_stall = miss_s;
      end
      ALLOC: begin
        cpu_stall   = 1'b1;
        fill_active = 1'b1;
      end
      FILL: begin
        cpu_stall   = 1'b1;
        fill_active = 1'b1;
        mem_req     = 1'b1;
        fill_wreq   = mem_ack & ~inv_all;
      end
      DONE: begin
        cpu_stall   = 1'b1;
        fill_active = 1'b1;
      end
      default: begin
        cpu_stall = 1'b0;
      end
    endcase
  end

  assign mem_addr   = word_addr(miss_tag_q, miss_set_q, wc_q);
  assign fill_addr  = mem_addr;
  assign fill_wdata = mem_rdata;

  // Miss capture, victim latch and word counter
  always_comb begin
    miss_tag_d = miss_tag_q;
    miss_set_d = miss_set_q;
    victim_d   = victim_q;
    wc_d       = wc_q;
    if (alloc_start_s) begin
      miss_tag_d = addr_tag(cpu_addr);
      miss_set_d = addr_set(cpu_addr);
      victim_d   = sel_victim_s;
    end else if (state_q == ALLOC) begin
      wc_d = 3'd0;
    end else if ((state_q == FILL) && mem_ack && !inv_all) begin
      wc_d = wc_q + 3'd1;
    end else begin
      wc_d = wc_q;
    end
  end

  // Per-line valid/tag/set updates; a flush clears every valid bit
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    set_d   = set_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (state_q == ALLOC) begin
      valid_d[victim_q] = 1'b0;
      tag_d[victim_q]   = miss_tag_q;
      set_d[victim_q]   = miss_set_q;
    end else if (state_q == DONE) begin
      valid_d[victim_q] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_tag_q <= '0;
      miss_set_q <= '0;
      victim_q   <= '0;
      wc_q       <= '0;
      valid_q    <= '0;
      tag_q      <= '0;
      set_q      <= '0;
    end else begin
      miss_tag_q <= miss_tag_d;
      miss_set_q <= miss_set_d;
      victim_q   <= victim_d;
      wc_q       <= wc_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      set_q      <= set_d;
    end
  end

  assign line_valid = valid_q;
  assign line_tag   = tag_q;
  assign line_set   = set_q;

`ifdef L1_REFILL_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] fill_cyc_q, fill_cyc_d;

  // Saturating event counters; a flush leaves them untouched
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill_cyc_d = fill_cyc_q;
    if (cpu_rreq && (|hit_vec)) begin
      hit_cnt_d = sat_inc32(hit_cnt_q);
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (alloc_start_s) begin
      miss_cnt_d = sat_inc32(miss_cnt_q);
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
    if (mem_req) begin
      fill_cyc_d = sat_inc32(fill_cyc_q);
    end else begin
      fill_cyc_d = fill_cyc_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      fill_cyc_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      fill_cyc_q <= fill_cyc_d;
    end
  end

  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign fill_cycles = fill_cyc_q;
`endif

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed, table-driven bench for l1_refill_ctrl with NUM_LINES=8.
module tb_l1_refill_ctrl;

  localparam int NL = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_rreq;
  logic              cpu_wreq;
  logic [31:0]       cpu_addr;
  logic              cpu_stall;
  logic [NL-1:0]     hit_vec;
  logic              inv_all;
  logic [NL-1:0]     line_valid;
  logic [NL*23-1:0]  line_tag;
  logic [NL*4-1:0]   line_set;
  logic              fill_active;
  logic              fill_wreq;
  logic [31:0]       fill_addr;
  logic [31:0]       fill_wdata;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
`ifdef L1_REFILL_STATS_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
  logic [31:0]       fill_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  l1_refill_ctrl #(.NUM_LINES(NL), .LINE_WORDS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_rreq    (cpu_rreq),
    .cpu_wreq    (cpu_wreq),
    .cpu_addr    (cpu_addr),
    .cpu_stall   (cpu_stall),
    .hit_vec     (hit_vec),
    .inv_all     (inv_all),
    .line_valid  (line_valid),
    .line_tag    (line_tag),
    .line_set    (line_set),
    .fill_active (fill_active),
    .fill_wreq   (fill_wreq),
    .fill_addr   (fill_addr),
    .fill_wdata  (fill_wdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef L1_REFILL_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .fill_cycles (fill_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          victim;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete miss/refill; inv_at >= 0 flushes on that word's ack
  task automatic run_fill(input logic [31:0] addr, input int victim,
                          input int lat, input int inv_at);
    logic [31:0] exp_a;
    logic [2:0]  w3;
    logic [22:0] exp_tag;
    logic [3:0]  exp_set;
    exp_tag  = addr[31:9];
    exp_set  = addr[8:5];
    cpu_rreq = 1'b1;
    cpu_addr = addr;
    hit_vec  = '0;
    @(negedge clk);
    chk("idle_stall", {63'd0, cpu_stall}, 64'd1);
    chk("idle_mreq", {63'd0, mem_req}, 64'd0);
    tick();
    @(negedge clk);
    chk("alloc_active", {63'd0, fill_active}, 64'd1);
    chk("alloc_mreq", {63'd0, mem_req}, 64'd0);
    tick();
    for (int w = 0; w < 8; w++) begin
      w3    = 3'(w);
      exp_a = {addr[31:5], w3, 2'b00};
      for (int l = 0; l < lat; l++) begin
        mem_ack = 1'b0;
        @(negedge clk);
        chk("wait_mreq", {63'd0, mem_req}, 64'd1);
        chk("wait_wreq", {63'd0, fill_wreq}, 64'd0);
        chk("wait_stall", {63'd0, cpu_stall}, 64'd1);
        tick();
      end
      mem_ack   = 1'b1;
      mem_rdata = exp_a ^ 32'hC0DE_0000;
      inv_all   = (w == inv_at);
      @(negedge clk);
      if (w == 0) begin
        chk("victim_cleared", {63'd0, line_valid[victim]}, 64'd0);
        chk("victim_tag", {41'd0, line_tag[23*victim +: 23]}, {41'd0, exp_tag});
        chk("victim_set", {60'd0, line_set[4*victim +: 4]}, {60'd0, exp_set});
      end
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, exp_a});
      chk("fill_addr", {32'd0, fill_addr}, {32'd0, exp_a});
      chk("fill_wdata", {32'd0, fill_wdata}, {32'd0, exp_a ^ 32'hC0DE_0000});
      chk("fill_wreq", {63'd0, fill_wreq}, (w == inv_at) ? 64'd0 : 64'd1);
      tick();
      mem_ack = 1'b0;
      inv_all = 1'b0;
      if (w == inv_at) begin
        @(negedge clk);
        chk("flush_valid", {56'd0, line_valid}, 64'd0);
        chk("flush_mreq", {63'd0, mem_req}, 64'd0);
        chk("flush_active", {63'd0, fill_active}, 64'd0);
        cpu_rreq = 1'b0;
        tick();
        return;
      end
    end
    @(negedge clk);
    chk("done_mreq", {63'd0, mem_req}, 64'd0);
    chk("done_active", {63'd0, fill_active}, 64'd1);
    chk("done_stall", {63'd0, cpu_stall}, 64'd1);
    tick();
    hit_vec = NL'(1) << victim;
    @(negedge clk);
    chk("line_valid_set", {63'd0, line_valid[victim]}, 64'd1);
    chk("replay_stall", {63'd0, cpu_stall}, 64'd0);
    chk("replay_active", {63'd0, fill_active}, 64'd0);
    cpu_rreq = 1'b0;
    hit_vec  = '0;
    tick();
  endtask

  initial begin
    tbl[0] = '{32'h0000_1A40, 0, 0};
    tbl[1] = '{32'h0000_2000, 1, 3};
    tbl[2] = '{32'h1234_5660, 2, 1};
    tbl[3] = '{32'hFFFF_FFE0, 3, 2};
    tbl[4] = '{32'h8000_0020, 4, 0};
    tbl[5] = '{32'h0ABC_DE00, 5, 1};
    tbl[6] = '{32'h7654_3200, 6, 0};
    tbl[7] = '{32'h0000_0100, 7, 2};
    tbl[8] = '{32'hDEAD_BEE0, 0, 1};
    tbl[9] = '{32'h0F0F_0F00, 1, 0};

    reset     = 1'b1;
    cpu_rreq  = 1'b0;
    cpu_wreq  = 1'b0;
    cpu_addr  = 32'd0;
    hit_vec   = '0;
    inv_all   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {56'd0, line_valid}, 64'd0);
    chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
    chk("rst_mreq", {63'd0, mem_req}, 64'd0);
    chk("rst_active", {63'd0, fill_active}, 64'd0);
    chk("rst_tag0", {41'd0, line_tag[22:0]}, 64'd0);
    tick();

    // Eight cold fills, then two round-robin replacements
    for (int i = 0; i < 10; i++) begin
      run_fill(tbl[i].addr, tbl[i].victim, tbl[i].lat, -1);
    end
    chk("all_valid", {56'd0, line_valid}, 64'hFF);
`ifdef L1_REFILL_STATS_EN
    chk("stat_miss", {32'd0, miss_cnt}, 64'd10);
    chk("stat_hit", {32'd0, hit_cnt}, 64'd10);
`endif

    // Write to an absent address never allocates
    cpu_wreq = 1'b1;
    cpu_addr = 32'h5555_5540;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wr_stall", {63'd0, cpu_stall}, 64'd0);
      chk("wr_mreq", {63'd0, mem_req}, 64'd0);
      chk("wr_active", {63'd0, fill_active}, 64'd0);
      tick();
    end
    cpu_wreq = 1'b0;

    // Flush on the 4th ack, then the re-request refetches from word 0 into line 0
    run_fill(32'h0003_0040, 2, 1, 3);
    run_fill(32'h0003_0040, 0, 1, -1);
    chk("refill_valid", {56'd0, line_valid}, 64'h01);

    // Flush and miss in the same idle cycle: flush wins
    cpu_rreq = 1'b1;
    cpu_addr = 32'h0004_0080;
    inv_all  = 1'b1;
    tick();
    inv_all  = 1'b0;
    cpu_rreq = 1'b0;
    @(negedge clk);
    chk("flushmiss_active", {63'd0, fill_active}, 64'd0);
    chk("flushmiss_valid", {56'd0, line_valid}, 64'd0);
    tick();

    // Reset in the middle of a fill
    cpu_rreq = 1'b1;
    cpu_addr = 32'h0005_00A0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_mreq", {63'd0, mem_req}, 64'd1);
    tick();
    reset    = 1'b1;
    cpu_rreq = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_mreq", {63'd0, mem_req}, 64'd0);
    chk("mid_rst_active", {63'd0, fill_active}, 64'd0);
    chk("mid_rst_stall", {63'd0, cpu_stall}, 64'd0);
    chk("mid_rst_valid", {56'd0, line_valid}, 64'd0);
    chk("mid_rst_tag0", {41'd0, line_tag[22:0]}, 64'd0);
    chk("mid_rst_mem_addr", {32'd0, mem_addr}, 64'd0);
`ifdef L1_REFILL_STATS_EN
    chk("mid_rst_hit", {32'd0, hit_cnt}, 64'd0);
    chk("mid_rst_miss", {32'd0, miss_cnt}, 64'd0);
    chk("mid_rst_fcyc", {32'd0, fill_cycles}, 64'd0);
`endif
    tick();

    // After reset the pointer restarts: fill all lines, the 9th miss picks line 0
    for (int i = 0; i < 9; i++) begin
      run_fill(tbl[i].addr, tbl[i].victim, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
